// File: rtl/fpmul_bus_pkg.sv
// Shared constants and state type for the FP multiplier bus driver.
// Mirrors the wrapper's 2-bit register map and status word layout.
package fpmul_bus_pkg;

  localparam logic [1:0] FPM_ADDR_OPA  = 2'd0;
  localparam logic [1:0] FPM_ADDR_OPB  = 2'd1;
  localparam logic [1:0] FPM_ADDR_RES  = 2'd2;  // product read / start write
  localparam logic [1:0] FPM_ADDR_STAT = 2'd3;

  localparam int FPM_STAT_DONE     = 0;
  localparam int FPM_STAT_START    = 16;
  localparam int FPM_STAT_FLAGS_LO = 8;
  localparam int FPM_STAT_FLAGS_HI = 13;

  localparam logic [31:0] FPM_START_WORD = 32'h0001_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_WR_GO,
    ST_GAP,
    ST_POLL,
    ST_RD_P,
    ST_RESP
  } fpm_drv_state_t;

endpackage

// File: rtl/fpmul_drv_timeout.sv
// Poll-cycle counter for the bus driver: synchronous clear, count enable,
// and a terminal-count flag raised once TIMEOUT-1 polls have elapsed.
module fpmul_drv_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/fpmul_bus_driver.sv
// Bus initiator that runs the FP multiplier wrapper's register sequence
// (write A, write B, start, poll, read product) for one operand pair at a time.
module fpmul_bus_driver
  import fpmul_bus_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_p,
  output logic [5:0]  res_flags,
  output logic        res_timeout,
  output logic        busy,
  output logic [1:0]  bus_a,
  output logic        bus_we,
  output logic [31:0] bus_wd,
  input  logic [31:0] bus_rd
);

  // Handshakes: a transfer occurs on a rising edge where valid and ready are
  // both high; valid never depends on ready, and res_* hold until accepted.

  fpm_drv_state_t state_q, state_d;
  logic [31:0]    op_a_q, op_a_d;
  logic [31:0]    op_b_q, op_b_d;
  logic [31:0]    res_p_q, res_p_d;
  logic [5:0]     flags_q, flags_d;
  logic           timeout_q, timeout_d;
  logic           to_clr, to_en, to_tc;
  logic           done;

  assign done = bus_rd[FPM_STAT_DONE];

  fpmul_drv_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (to_clr),
    .en  (to_en),
    .tc  (to_tc)
  );

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    res_p_d   = res_p_q;
    flags_d   = flags_q;
    timeout_d = timeout_q;
    to_clr    = 1'b0;
    to_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_a_d  = req_a;
          op_b_d  = req_b;
          state_d = ST_WR_A;
        end
      end
      ST_WR_A:  state_d = ST_WR_B;
      ST_WR_B:  state_d = ST_WR_GO;
      ST_WR_GO: begin
        to_clr  = 1'b1;
        state_d = ST_GAP;
      end
      // The wrapper may still show the previous done right after start.
      ST_GAP:   state_d = ST_POLL;
      ST_POLL: begin
        if (done) begin
          flags_d = bus_rd[FPM_STAT_FLAGS_HI:FPM_STAT_FLAGS_LO];
          state_d = ST_RD_P;
        end else if (to_tc) begin
          res_p_d   = '0;
          flags_d   = '0;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          to_en = 1'b1;
        end
      end
      ST_RD_P: begin
        res_p_d = bus_rd;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) begin
          timeout_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      res_p_q   <= '0;
      flags_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      res_p_q   <= res_p_d;
      flags_q   <= flags_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    bus_a  = FPM_ADDR_STAT;
    bus_we = 1'b0;
    bus_wd = '0;
    case (state_q)
      ST_WR_A: begin
        bus_a  = FPM_ADDR_OPA;
        bus_we = 1'b1;
        bus_wd = op_a_q;
      end
      ST_WR_B: begin
        bus_a  = FPM_ADDR_OPB;
        bus_we = 1'b1;
        bus_wd = op_b_q;
      end
      ST_WR_GO: begin
        bus_a  = FPM_ADDR_RES;
        bus_we = 1'b1;
        bus_wd = FPM_START_WORD;
      end
      ST_RD_P:  bus_a = FPM_ADDR_RES;
      default:  ;
    endcase
  end

  // Gated by rst so nothing is accepted while reset is held.
  assign req_ready   = rst && (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign res_valid   = (state_q == ST_RESP);
  assign res_p       = res_p_q;
  assign res_flags   = flags_q;
  assign res_timeout = timeout_q;

endmodule

// File: tb/tb_fpmul_bus_driver.sv
// Bench for fpmul_bus_driver: wrapper responder model, per-cycle behavioural
// model with an expected-result queue, directed cases and a randomized run.
module tb_fpmul_bus_driver;

  localparam int          TIMEOUT    = 16;
  localparam logic [31:0] START_WORD = 32'h0001_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_p;
  logic [5:0]  res_flags;
  logic        res_timeout;
  logic        busy;
  logic [1:0]  bus_a;
  logic        bus_we;
  logic [31:0] bus_wd;
  logic [31:0] bus_rd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded limit 500000", $time);
    $fatal(1, "watchdog");
  end

  fpmul_bus_driver #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_p       (res_p),
    .res_flags   (res_flags),
    .res_timeout (res_timeout),
    .busy        (busy),
    .bus_a       (bus_a),
    .bus_we      (bus_we),
    .bus_wd      (bus_wd),
    .bus_rd      (bus_rd)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stand-in for the multiplier's arithmetic: deterministic, with the
  // directed operand pairs giving their true IEEE products and flags.
  function automatic logic [31:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return {a[31] ^ b[31], a[30:0] ^ {b[15:0], b[30:16]}};
  endfunction

  function automatic logic [5:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return 6'b000001;
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 6'b000000;
    return a[5:0] ^ b[13:8];
  endfunction

  // ---------------- wrapper responder ----------------
  logic [31:0] w_opa = '0, w_opb = '0, w_prod = '0;
  logic [5:0]  w_flags = '0;
  logic        w_done = 1'b0, w_start = 1'b0, w_clr_pend = 1'b0;
  int          w_cnt = 0;
  int          cfg_lat = 4;
  bit          cfg_never = 0, cfg_late = 0, cfg_stale = 0;
  logic [33:0] wr_log[$];
  logic [31:0] w_status;

  assign w_status = {15'd0, w_start, 2'd0, w_flags, 7'd0, w_done};
  assign bus_rd = (bus_a == 2'd2) ? w_prod :
                  (bus_a == 2'd3) ? w_status :
                  (bus_a == 2'd0) ? w_opa : w_opb;

  always @(posedge clk) begin
    if (cfg_stale) begin
      w_done  <= 1'b1;
      w_prod  <= 32'hDEAD_BEEF;
      w_flags <= 6'h2A;
    end
    if (bus_we) wr_log.push_back({bus_a, bus_wd});
    if (bus_we && bus_a == 2'd0) w_opa <= bus_wd;
    if (bus_we && bus_a == 2'd1) w_opb <= bus_wd;
    if (bus_we && bus_a == 2'd2 && bus_wd[16]) begin
      w_start <= 1'b1;
      w_cnt   <= cfg_never ? 0 : cfg_lat;
      if (cfg_late) w_clr_pend <= 1'b1;
      else          w_done     <= 1'b0;
    end else begin
      if (w_clr_pend) begin
        w_done     <= 1'b0;
        w_clr_pend <= 1'b0;
      end
      if (w_cnt != 0) begin
        w_cnt <= w_cnt - 1;
        if (w_cnt == 1) begin
          w_done  <= 1'b1;
          w_prod  <= ref_prod(w_opa, w_opb);
          w_flags <= ref_flags(w_opa, w_opb);
        end
      end
    end
  end

  // ---------------- res_ready driver ----------------
  int rr_mode = 1;  // 0 hold low, 1 hold high, 2 random
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       res_ready = 1'b0;
      1:       res_ready = 1'b1;
      default: res_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- behavioural model + scoreboard ----------------
  int          m_t = 0;      // cycles since acceptance, 0 when idle
  int          m_poll = 0;
  bit          m_rd = 0, m_resp = 0;
  logic [31:0] m_a = '0, m_b = '0;
  int          m_acc_cyc = 0, m_hs_cyc = 0, n_resp = 0;
  logic [38:0] exp_q[$];     // {timeout, flags, product}
  logic [31:0] exp_wd;

  always @(negedge clk) begin
    if (!rst) begin
      m_t = 0; m_rd = 0; m_resp = 0;
      exp_q.delete();
      chk("rst_bus_we", bus_we, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bus_a", bus_a, 3);
      chk("rst_bus_wd", bus_wd, 0);
      chk("rst_res_timeout", res_timeout, 0);
    end else if (m_resp) begin
      chk("resp_valid", res_valid, 1);
      chk("resp_req_ready", req_ready, 0);
      chk("resp_busy", busy, 1);
      chk("resp_bus_we", bus_we, 0);
      chk("resp_p", res_p, exp_q[0][31:0]);
      chk("resp_flags", res_flags, exp_q[0][37:32]);
      chk("resp_timeout", res_timeout, exp_q[0][38]);
      if (res_ready) begin
        void'(exp_q.pop_front());
        m_resp = 0; m_t = 0; m_hs_cyc = cyc; n_resp++;
      end
    end else if (m_t == 0) begin
      chk("idle_req_ready", req_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_bus_we", bus_we, 0);
      chk("idle_bus_a", bus_a, 3);
      chk("idle_res_valid", res_valid, 0);
      if (req_valid) begin
        m_a = req_a; m_b = req_b; m_t = 1; m_acc_cyc = cyc;
      end
    end else begin
      chk("act_busy", busy, 1);
      chk("act_req_ready", req_ready, 0);
      chk("act_res_valid", res_valid, 0);
      if (m_t <= 3) begin
        exp_wd = (m_t == 1) ? m_a : (m_t == 2) ? m_b : START_WORD;
        chk("wr_we", bus_we, 1);
        chk("wr_addr", bus_a, 64'(m_t - 1));
        chk("wr_data", bus_wd, exp_wd);
        m_t++;
      end else if (m_t == 4) begin
        chk("gap_we", bus_we, 0);
        chk("gap_addr", bus_a, 3);
        m_t = 5; m_poll = 0;
      end else if (m_rd) begin
        chk("rd_we", bus_we, 0);
        chk("rd_addr", bus_a, 2);
        exp_q.push_back({1'b0, ref_flags(m_a, m_b), ref_prod(m_a, m_b)});
        m_rd = 0; m_resp = 1;
      end else begin
        chk("poll_we", bus_we, 0);
        chk("poll_addr", bus_a, 3);
        m_poll++;
        if (w_done) begin
          m_rd = 1;
        end else if (m_poll == TIMEOUT) begin
          exp_q.push_back({1'b1, 6'd0, 32'd0});
          m_resp = 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    req_valid = 1'b1; req_a = a; req_b = b;
  endtask

  task automatic finish_req();
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!req_ready && n < 300);
    chk("accept_bound", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    start_req(a, b);
    finish_req();
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!res_valid && n < 300) begin
      @(negedge clk); n++;
    end
    chk("resp_bound", res_valid, 1);
  endtask

  task automatic wait_resp(output logic [31:0] p, output logic [5:0] f, output logic to,
                           output int lat);
    @(negedge clk);
    wait_valid();
    p = res_p; f = res_flags; to = res_timeout;
    lat = cyc - m_acc_cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (busy && n < 300);
    chk("idle_bound", busy, 0);
  endtask

  task automatic pulse_stale();
    @(posedge clk); #1 cfg_stale = 1;
    @(posedge clk); #1 cfg_stale = 0;
  endtask

  // ---------------- test sequence ----------------
  logic [31:0] p;
  logic [5:0]  f;
  logic        to;
  int          lat;

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;

    // nominal 2.0 * 3.0, 4-cycle multiplier
    wr_log.delete();
    send(32'h4000_0000, 32'h4040_0000);
    wait_resp(p, f, to, lat);
    chk("nom_p", p, 32'h40C0_0000);
    chk("nom_flags", f, 0);
    chk("nom_timeout", to, 0);
    chk("nom_latency", lat, 10);
    chk("nom_wr_count", wr_log.size(), 3);
    chk("nom_wr0", wr_log[0], {2'd0, 32'h4000_0000});
    chk("nom_wr1", wr_log[1], {2'd1, 32'h4040_0000});
    chk("nom_wr2", wr_log[2], {2'd2, 32'h0001_0000});
    wait_idle();

    // zero operand
    send(32'h0000_0000, 32'h40A0_0000);
    wait_resp(p, f, to, lat);
    chk("zero_p", p, 0);
    chk("zero_flags", f, 6'b000001);
    wait_idle();

    // done arrives on the last permitted poll: done wins over terminal count
    cfg_lat = 16;
    send(32'h4000_0000, 32'h4040_0000);
    wait_resp(p, f, to, lat);
    chk("lastpoll_timeout", to, 0);
    chk("lastpoll_p", p, 32'h40C0_0000);
    chk("lastpoll_latency", lat, 22);
    wait_idle();

    // timeout: done never set, 16 polls
    cfg_never = 1;
    send(32'h3F80_0000, 32'h3F80_0000);
    wait_resp(p, f, to, lat);
    chk("to_timeout", to, 1);
    chk("to_p", p, 0);
    chk("to_flags", f, 0);
    chk("to_latency", lat, 21);
    wait_idle();

    // stale done from an earlier run, cleared one cycle after start
    cfg_never = 0; cfg_lat = 3; cfg_late = 1;
    pulse_stale();
    send(32'h4000_0000, 32'h4040_0000);
    wait_resp(p, f, to, lat);
    chk("stale_p", p, 32'h40C0_0000);
    chk("stale_flags", f, 0);
    chk("stale_latency", lat, 9);
    wait_idle();
    cfg_late = 0; cfg_lat = 4;

    // backpressure with a second request waiting
    rr_mode = 0;
    send(32'h4000_0000, 32'h4040_0000);
    wait_valid();
    #2 req_valid = 1'b1; req_a = 32'h0000_0000; req_b = 32'h40A0_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_p", res_p, 32'h40C0_0000);
      chk("bp_flags", res_flags, 0);
      chk("bp_req_ready", req_ready, 0);
    end
    rr_mode = 1;
    finish_req();
    chk("bp_accept_gap", m_acc_cyc - m_hs_cyc, 1);
    wait_resp(p, f, to, lat);
    chk("bp2_p", p, 0);
    chk("bp2_flags", f, 6'b000001);
    wait_idle();

    // reset while polling
    cfg_never = 1;
    send(32'h4000_0000, 32'h4040_0000);
    repeat (8) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_bus_we", bus_we, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("postrst_req_ready", req_ready, 1);
    cfg_never = 0; cfg_lat = 4;
    send(32'h4000_0000, 32'h4040_0000);
    wait_resp(p, f, to, lat);
    chk("postrst_p", p, 32'h40C0_0000);
    chk("postrst_latency", lat, 10);
    wait_idle();

    // randomized traffic with random result backpressure
    rr_mode = 2;
    for (int t = 0; t < 30; t++) begin
      int target;
      int n;
      logic [31:0] ra, rb;
      cfg_lat   = $urandom_range(1, 18);
      cfg_never = ($urandom_range(0, 7) == 0);
      cfg_late  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) pulse_stale();
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 5) == 0) ra = {ra[31], 31'd0};
      target = n_resp + 1;
      send(ra, rb);
      n = 0;
      while (n_resp < target && n < 300) begin
        @(negedge clk); n++;
      end
      chk("rand_resp_bound", n_resp >= target, 1);
    end

    rr_mode = 1;
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
